// File: rtl/sensor_pkg.sv
// sensor_pkg -- shared definitions for the multi-channel laser-target hit sensor.
//
// Contents:
//   sensor_state_t : per-channel FSM state (IDLE, QUAL, LOCK, WAIT_LOW), 2-bit.
//   *_DEF          : default values for HOLD_CYCLES, LOCKOUT and CNT_W.
//   id_width()     : width of the hit_id output for a given channel count.
//   cnt_width()    : counter width able to hold values 0..n-1, never below 1.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    LOCK     = 2'd2,
    WAIT_LOW = 2'd3
  } sensor_state_t;

  localparam int HOLD_CYCLES_DEF = 4;
  localparam int LOCKOUT_DEF     = 16;
  localparam int CNT_W_DEF       = 8;

  function automatic int id_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_chan.sv
// sensor_chan -- one hit-sensor channel.
//
// A 2-flop synchroniser feeds a four-state FSM: a hit qualifies after
// HOLD_CYCLES consecutive synchronised-high samples, produces a one-cycle
// pulse, ignores the input for LOCKOUT cycles and then waits for the beam to
// go away before re-arming.
//
// Optional feature (macro SENSOR_HIT_COUNT_EN): saturating CNT_W-bit counter
// of pulses, cleared only by reset.
//
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_sensor : raw asynchronous detector input, active-high
//   o_pulse  : registered one-cycle hit pulse
//   o_count  : pulse counter (SENSOR_HIT_COUNT_EN only)
module sensor_chan
  import sensor_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int LOCKOUT     = LOCKOUT_DEF
`ifdef SENSOR_HIT_COUNT_EN
  ,
  parameter int CNT_W       = CNT_W_DEF
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sensor,
  output logic             o_pulse
`ifdef SENSOR_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_count
`endif
);

  localparam int QW = cnt_width(HOLD_CYCLES + 1);
  localparam int LW = cnt_width(LOCKOUT + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);

  logic          r_sync_p0;
  logic          r_sync_p1;
  sensor_state_t r_state;
  logic [QW-1:0] r_qcnt;
  logic [LW-1:0] r_lcnt;
  logic          r_pulse;

  sensor_state_t w_state_nx;
  logic [QW-1:0] w_qcnt_nx;
  logic [LW-1:0] w_lcnt_nx;
  logic          w_pulse_nx;
  logic          w_s;

  // With a zero-length lockout the channel skips LOCK entirely.
  function automatic sensor_state_t after_hit();
    return (LOCKOUT == 0) ? WAIT_LOW : LOCK;
  endfunction

  assign w_s = r_sync_p1;

  always_comb begin
    w_state_nx = r_state;
    w_qcnt_nx  = r_qcnt;
    w_lcnt_nx  = r_lcnt;
    w_pulse_nx = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          if (HOLD_CYCLES == 1) begin
            w_state_nx = after_hit();
            w_pulse_nx = 1'b1;
            w_lcnt_nx  = '0;
          end else begin
            w_state_nx = QUAL;
            w_qcnt_nx  = QW'(1);
          end
        end
      end
      QUAL: begin
        if (!w_s) begin
          w_state_nx = IDLE;
        end else if (r_qcnt == Q_LAST) begin
          w_state_nx = after_hit();
          w_pulse_nx = 1'b1;
          w_lcnt_nx  = '0;
        end else begin
          w_qcnt_nx = r_qcnt + 1'b1;
        end
      end
      LOCK: begin
        if (r_lcnt == L_LAST) w_state_nx = WAIT_LOW;
        else                  w_lcnt_nx  = r_lcnt + 1'b1;
      end
      WAIT_LOW: begin
        if (!w_s) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Synchroniser stages p0/p1, then FSM/counter/pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_state   <= IDLE;
      r_qcnt    <= '0;
      r_lcnt    <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync_p0 <= i_sensor;
      r_sync_p1 <= r_sync_p0;
      r_state   <= w_state_nx;
      r_qcnt    <= w_qcnt_nx;
      r_lcnt    <= w_lcnt_nx;
      r_pulse   <= w_pulse_nx;
    end
  end

  assign o_pulse = r_pulse;

`ifdef SENSOR_HIT_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_count <= '0;
    else if (r_pulse && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
`endif

endmodule

// File: rtl/multi_sensor_hit.sv
// multi_sensor_hit -- N-channel laser-target hit sensor.
//
// Instantiates one sensor_chan per channel, keeps sticky hit flags that the
// CPU clears with a per-channel ack strobe (a new hit on the same cycle as its
// ack wins), and reports the lowest-index flagged channel.
//
// Optional feature (macro SENSOR_HIT_COUNT_EN): per-channel saturating hit
// counters exported on hit_count; the port is absent when undefined.
//
// Ports:
//   clk       : system clock
//   CLR       : asynchronous active-low reset
//   sensor    : [N_CH] raw detector inputs, active-high
//   ack       : [N_CH] sticky-flag clear strobe
//   hit_pulse : [N_CH] one-cycle pulse per qualified hit
//   hit_flags : [N_CH] sticky hit flags
//   hit_valid : OR of hit_flags
//   hit_id    : lowest set flag index, 0 when none
//   hit_count : [N_CH*CNT_W] packed counters (SENSOR_HIT_COUNT_EN only)
module multi_sensor_hit
  import sensor_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int LOCKOUT     = LOCKOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      CLR,
  input  logic [N_CH-1:0]           sensor,
  input  logic [N_CH-1:0]           ack,
  output logic [N_CH-1:0]           hit_pulse,
  output logic [N_CH-1:0]           hit_flags,
  output logic                      hit_valid,
  output logic [id_width(N_CH)-1:0] hit_id
`ifdef SENSOR_HIT_COUNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]     hit_count
`endif
);

  localparam int IDW = id_width(N_CH);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("multi_sensor_hit: N_CH must be 1..16");
  end
  if (HOLD_CYCLES < 1 || LOCKOUT < 0 || CNT_W < 1) begin : g_bad_param
    $error("multi_sensor_hit: HOLD_CYCLES>=1, LOCKOUT>=0, CNT_W>=1 required");
  end

  logic [N_CH-1:0] w_pulse;
  logic [N_CH-1:0] r_flags;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sensor_chan #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .LOCKOUT    (LOCKOUT)
`ifdef SENSOR_HIT_COUNT_EN
      ,
      .CNT_W      (CNT_W)
`endif
    ) u_chan (
      .i_clk   (clk),
      .i_rst_n (CLR),
      .i_sensor(sensor[i]),
      .o_pulse (w_pulse[i])
`ifdef SENSOR_HIT_COUNT_EN
      ,
      .o_count (hit_count[i*CNT_W +: CNT_W])
`endif
    );
  end

  // Sticky flags: the set term is ORed after the ack clear so a hit wins.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) r_flags <= '0;
    else      r_flags <= (r_flags & ~ack) | w_pulse;
  end

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    hit_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_flags[i]) hit_id = IDW'(i);
    end
  end

  assign hit_pulse = w_pulse;
  assign hit_flags = r_flags;
  assign hit_valid = |r_flags;

endmodule

// File: tb/tb_multi_sensor_hit.sv
module tb_multi_sensor_hit;

  localparam int N_CH      = 4;
  localparam int HOLD      = 4;
  localparam int LOCKOUT_C = 16;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   CLR;
  logic [N_CH-1:0]        sensor;
  logic [N_CH-1:0]        ack;
  logic [N_CH-1:0]        hit_pulse;
  logic [N_CH-1:0]        hit_flags;
  logic                   hit_valid;
  logic [1:0]             hit_id;
`ifdef SENSOR_HIT_COUNT_EN
  logic [N_CH*CNT_W-1:0]  hit_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int obs;

  multi_sensor_hit #(
    .N_CH       (N_CH),
    .HOLD_CYCLES(HOLD),
    .LOCKOUT    (LOCKOUT_C),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .CLR      (CLR),
    .sensor   (sensor),
    .ack      (ack),
    .hit_pulse(hit_pulse),
    .hit_flags(hit_flags),
    .hit_valid(hit_valid),
    .hit_id   (hit_id)
`ifdef SENSOR_HIT_COUNT_EN
    ,
    .hit_count(hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by run length of high samples while armed,
  // an edge number until which input is ignored, and a "needs low" flag.
  // The detector sees the raw input two clock edges late.
  bit           s1_m [N_CH];
  bit           s2_m [N_CH];
  int           run_m [N_CH];
  int           block_m [N_CH];
  bit           need_low_m [N_CH];
  int           cnt_m [N_CH];
  logic [N_CH-1:0] pulse_m = '0;
  logic [N_CH-1:0] flags_m = '0;
  int           cyc = 0;

  function automatic int low_idx(input logic [N_CH-1:0] f);
    int r;
    r = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (f[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [N_CH-1:0] np;
    bit d;
    cyc++;
    if (!CLR) begin
      for (int i = 0; i < N_CH; i++) begin
        s1_m[i] = 0; s2_m[i] = 0; run_m[i] = 0; block_m[i] = -1;
        need_low_m[i] = 0; cnt_m[i] = 0;
      end
      pulse_m = '0;
      flags_m = '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (pulse_m[i] && cnt_m[i] < CNT_MAX) cnt_m[i]++;
      flags_m = (flags_m & ~ack) | pulse_m;
      np = '0;
      for (int i = 0; i < N_CH; i++) begin
        d = s2_m[i];
        s2_m[i] = s1_m[i];
        s1_m[i] = sensor[i];
        if (cyc > block_m[i]) begin
          if (need_low_m[i]) begin
            if (!d) need_low_m[i] = 0;
          end else if (d) begin
            run_m[i]++;
            if (run_m[i] == HOLD) begin
              np[i] = 1'b1;
              run_m[i] = 0;
              block_m[i] = cyc + LOCKOUT_C;
              need_low_m[i] = 1;
            end
          end else begin
            run_m[i] = 0;
          end
        end
      end
      pulse_m = np;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #3;
    check("pulse", hit_pulse, pulse_m);
    check("flags", hit_flags, flags_m);
    check("valid", hit_valid, |flags_m);
    check("id", hit_id, low_idx(flags_m));
`ifdef SENSOR_HIT_COUNT_EN
    for (int i = 0; i < N_CH; i++)
      check("count", hit_count[i*CNT_W +: CNT_W], cnt_m[i]);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input int ch, input bit v, input int n);
    @(negedge clk);
    sensor[ch] = v;
    repeat (n) begin
      @(posedge clk);
      #3;
      if (hit_pulse[ch]) obs++;
    end
  endtask

  task automatic wait_pulse(input int ch, input int max, output int edge_no);
    edge_no = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk);
      #3;
      if (hit_pulse[ch]) begin
        edge_no = k;
        break;
      end
    end
    check("pulse_timeout", (edge_no > 0), 1);
  endtask

  task automatic pulse_ack(input logic [N_CH-1:0] m);
    @(negedge clk);
    ack = m;
    @(negedge clk);
    ack = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    CLR = 1'b0;
    repeat (2) @(negedge clk);
    CLR = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int pe;
    int np;
`ifdef SENSOR_HIT_COUNT_EN
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
`endif
    CLR = 1'b0;
    sensor = '0;
    ack = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_pulse", hit_pulse, 0);
    check("rst_flags", hit_flags, 0);
    check("rst_valid", hit_valid, 0);
    check("rst_id", hit_id, 0);
    @(negedge clk);
    CLR = 1'b1;

    // Glitch rejection: one-cycle highs on channel 0.
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sensor[0] = ~sensor[0];
      @(posedge clk);
      #3;
      if (hit_pulse[0]) np++;
    end
    obs = 0;
    hold(0, 0, 4);
    check("glitch_pulses", np + obs, 0);
    check("glitch_flags", hit_flags, 0);

    // Qualified hit: pulse only on edge 6, exactly once over 50 cycles.
    @(negedge clk);
    sensor[1] = 1'b1;
    pe = -1;
    np = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #3;
      if (hit_pulse[1]) begin
        np++;
        if (pe < 0) pe = k;
      end
      if (k == 10) begin
        check("qual_flags", hit_flags, 4'b0010);
        check("qual_valid", hit_valid, 1);
        check("qual_id", hit_id, 1);
      end
    end
    check("qual_edge", pe, 6);
    check("qual_once", np, 1);
    obs = 0;
    hold(1, 0, 25);
    pulse_ack(4'b0010);

    // Lockout and re-arm on channel 2.
    @(negedge clk);
    sensor[2] = 1'b1;
    wait_pulse(2, 10, pe);
    obs = 0;
    hold(2, 0, 2);
    hold(2, 1, 6);
    hold(2, 1, 12);
    check("lock_no_retrigger", obs, 0);
    obs = 0;
    hold(2, 0, 3);
    hold(2, 1, 6);
    hold(2, 0, 25);
    check("rearm_pulse", obs, 1);
    pulse_ack(4'b0100);

    // Priority and ack.
    @(negedge clk);
    sensor[3] = 1'b1;
    sensor[1] = 1'b1;
    obs = 0;
    hold(3, 1, 6);
    hold(3, 0, 1);
    sensor[1] = 1'b0;
    hold(3, 0, 25);
    check("prio_flags", hit_flags, 4'b1010);
    check("prio_id", hit_id, 1);
    pulse_ack(4'b0010);
    @(posedge clk);
    #3;
    check("ack1_id", hit_id, 3);
    check("ack1_flags", hit_flags, 4'b1000);
    @(negedge clk);
    sensor[3] = 1'b1;
    wait_pulse(3, 10, pe);
    @(negedge clk);
    ack = 4'b1000;
    sensor[3] = 1'b0;
    @(posedge clk);
    #3;
    check("ack_set_wins", hit_flags[3], 1);
    @(negedge clk);
    ack = '0;
    obs = 0;
    hold(3, 0, 25);
    pulse_ack(4'b1000);
    pulse_ack(4'b0001);
    @(posedge clk);
    #3;
    check("ack_clear_flags", hit_flags, 0);
    check("ack_clear_valid", hit_valid, 0);

    // Reset mid-QUAL, then a 4-cycle input pulses at edge 6.
    @(negedge clk);
    sensor[0] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    CLR = 1'b0;
    #1;
    check("rstq_pulse", hit_pulse, 0);
    check("rstq_flags", hit_flags, 0);
    sensor[0] = 1'b0;
    repeat (2) @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    sensor[0] = 1'b1;
    pe = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #3;
      if (hit_pulse[0] && pe < 0) pe = k;
      if (k == 4) begin
        @(negedge clk);
        sensor[0] = 1'b0;
      end
    end
    check("rst_rearm_edge", pe, 6);

    // Reset mid-LOCK with a flag set.
    @(negedge clk);
    sensor[1] = 1'b1;
    wait_pulse(1, 10, pe);
    repeat (3) @(posedge clk);
    #3;
    check("rstl_pre_flag", hit_flags[1], 1);
    @(negedge clk);
    CLR = 1'b0;
    sensor[1] = 1'b0;
    #1;
    check("rstl_flags", hit_flags, 0);
    check("rstl_valid", hit_valid, 0);
    check("rstl_id", hit_id, 0);
    check("rstl_pulse", hit_pulse, 0);
    repeat (2) @(negedge clk);
    CLR = 1'b1;
    obs = 0;
    hold(1, 0, 5);
    check("rstl_after", hit_flags, 0);

`ifdef SENSOR_HIT_COUNT_EN
    // Saturating counter on channel 0.
    do_reset();
    for (int h = 0; h < 5; h++) begin
      obs = 0;
      hold(0, 1, 5);
      hold(0, 0, 25);
      check("cnt_val", hit_count[CNT_W-1:0], exp_cnt[h]);
    end
`endif

    repeat (3) @(posedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_sensor_hit.md
Name: multi_sensor_hit

Overview:
- N-channel successor to the single-channel hit sensor for the laser-gun targets.
- Per channel: synchronises the raw photodetector input and rejects glitches shorter than HOLD_CYCLES.
- Per channel: emits a one-cycle hit pulse, then applies a lockout window and requires the beam to go away before re-arming.
- Aggregates hits into sticky flags plus a lowest-index "first hit" ID, which the CPU reads and acknowledges through its I/O block.

Parameters:
- N_CH, 4, number of sensor channels (1..16).
- HOLD_CYCLES, 4, consecutive synchronised-high samples required to qualify a hit (>=1).
- LOCKOUT, 16, cycles after a hit during which the channel ignores its input (>=0).
- CNT_W, 8, width of each per-channel hit counter (HIT_COUNT_EN only).

Ports:
- clk  in  1  system clock.
- CLR  in  1  reset; asynchronous, active-low.
- sensor  in  N_CH  raw asynchronous detector inputs, active-high.
- ack  in  N_CH  per-channel sticky-flag clear mask; single-cycle strobe.
- hit_pulse  out  N_CH  one-cycle pulse per qualified hit.
- hit_flags  out  N_CH  sticky hit flags.
- hit_valid  out  1  OR of hit_flags.
- hit_id  out  max(1,$clog2(N_CH))  index of the lowest set flag; 0 when hit_valid=0.
- hit_count  out  N_CH*CNT_W  packed per-channel counters, channel i at [i*CNT_W +: CNT_W]. Present only with HIT_COUNT_EN.

Behaviour:
- Reset (CLR=0, async):
  - sync flops, FSM state, qual/lock counters, hit_pulse, hit_flags and hit_count all go to 0.
  - Every FSM returns to IDLE immediately, mid-qualification or mid-lockout included.
  - Outputs are 0 while CLR=0.
- Synchroniser: 2-flop per channel; s[i] is stage-2 output.
- Per-channel FSM, states:
  - IDLE: if s=1 -> QUAL, qcnt=1. If HOLD_CYCLES=1, go directly to LOCK and pulse.
  - QUAL:
    - s=0 -> IDLE, glitch rejected, no pulse.
    - s=1 with qcnt==HOLD_CYCLES-1 -> LOCK, hit_pulse=1 for that cycle, lcnt=0.
    - else qcnt++.
  - LOCK: input ignored; lcnt++. When lcnt==LOCKOUT-1 -> WAIT_LOW. If LOCKOUT=0, LOCK lasts 0 cycles and the FSM goes directly to WAIT_LOW.
  - WAIT_LOW: s=0 -> IDLE. A held beam never retriggers.
- Latency: sensor held high from a sampling edge gives hit_pulse registered on edge HOLD_CYCLES+2 counting that edge as 1. hit_pulse is high exactly one cycle.
- Minimum re-hit spacing: HOLD_CYCLES+LOCKOUT+1 cycles after the pulse, given the input drops immediately and rises again.
- hit_flags[i]:
  - Set on the cycle after hit_pulse[i].
  - Cleared by ack[i].
  - Simultaneous set and ack on the same channel: set wins, flag stays 1.
  - ack on a clear flag: no effect.
- hit_valid and hit_id are combinational from hit_flags; priority goes to the lowest index.
- Counters: qcnt is $clog2(HOLD_CYCLES+1) bits wide; lcnt is $clog2(LOCKOUT+1) bits wide. No wrap is possible by construction.

Optional Feature:
- Macro: SENSOR_HIT_COUNT_EN.
- Defined:
  - Per-channel CNT_W-bit counter, incremented on each hit_pulse.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset; ack does not affect it.
  - hit_count port exists.
- Undefined:
  - No counters, and the hit_count port is absent.
  - All other behaviour is identical.

Decomposition:
- Shared package sensor_pkg:
  - FSM state typedef (IDLE, QUAL, LOCK, WAIT_LOW), 2-bit encoding.
  - Default constants for HOLD_CYCLES, LOCKOUT and CNT_W.
  - Function computing the hit_id width.
- Sub-module sensor_chan: synchroniser + FSM + qual/lock counters, with optional counter, for one channel.
- Top level: generates N_CH instances, plus the flag registers and the priority encoder.

Test Plan:
All scenarios use N_CH=4, HOLD_CYCLES=4, LOCKOUT=16.
- Glitch rejection: sensor[0] toggles every cycle for 20 cycles -> no hit_pulse; hit_flags=0; FSM never leaves QUAL/IDLE.
- Qualified hit: sensor[1] held high 10 cycles from edge 1 -> hit_pulse[1] high only on edge 6; hit_flags=4'b0010; hit_valid=1; hit_id=1. Sensor held high 50 cycles -> exactly one pulse.
- Lockout and re-arm:
  - After the first hit, drop sensor[2] for 2 cycles inside lockout and reassert it for 6 -> no second pulse.
  - Drop it after WAIT_LOW, then hold high 6 cycles -> second pulse.
- Priority and ack:
  - Hit channels 3 and 1 -> hit_id=1.
  - ack=4'b0010 -> hit_id=3.
  - ack[3] on the same cycle hit_flags[3] is set again -> flag stays 1.
- Reset mid-operation: assert CLR=0 mid-QUAL and mid-LOCK -> all outputs 0 immediately. Release -> a 4-high-cycle input again pulses at edge 6 after release.
- SENSOR_HIT_COUNT_EN with CNT_W=2: 5 spaced hits on channel 0 -> hit_count[1:0] reads 1,2,3,3,3.
